// File: rtl/mem_dump_reader_if.sv
// Bus bundle between the memory dump reader and its environment: the start
// command, the memory read port and the valid/ready output stream.
// The slave modport is the reader's view; the master modport is the harness view.
interface mem_dump_reader_if #(
    parameter int BITSIZE = 32,
    parameter int REGSIZE = 16
);
    // Command side
    logic               start;
    logic [REGSIZE-1:0] base_addr;
    logic [REGSIZE-1:0] word_count;
    logic               abort;

    // Memory asynchronous read port
    logic [REGSIZE-1:0] mem_addr;
    logic [BITSIZE-1:0] mem_rdata;
    logic               busy;

    // Output stream and status
    logic [BITSIZE-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               done;
    logic               err;
    logic [BITSIZE-1:0] checksum;

    modport slave (
        input  start, base_addr, word_count, abort, mem_rdata, out_ready,
        output mem_addr, busy, out_data, out_valid, out_last, done, err, checksum
    );

    modport master (
        output start, base_addr, word_count, abort, mem_rdata, out_ready,
        input  mem_addr, busy, out_data, out_valid, out_last, done, err, checksum
    );
endinterface

// File: rtl/mem_dump_reader.sv
// Memory readback engine. On an accepted start it walks base_addr ..
// base_addr+word_count-1 through the memory's asynchronous read port and
// streams each word over a valid/ready interface, keeping a running wrapping
// sum of the accepted words. While busy it owns the memory address bus.
module mem_dump_reader #(
    parameter int BITSIZE   = 32,
    parameter int REGSIZE   = 16,
    parameter int MEM_DEPTH = 100
) (
    input  logic               clk,
    input  logic               reset,
    mem_dump_reader_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One past the last legal word address, widened so the range check
    // base_addr + word_count cannot wrap.
    localparam logic [REGSIZE:0]   C_MEM_LIMIT = (REGSIZE+1)'(MEM_DEPTH);
    localparam logic [REGSIZE-1:0] C_ONE       = REGSIZE'(1);

    // Registered state
    state_t             r_state;
    logic [REGSIZE-1:0] r_addr;
    logic [REGSIZE-1:0] r_remaining;
    logic [BITSIZE-1:0] r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_done;
    logic               r_err;
    logic [BITSIZE-1:0] r_checksum;

    // Next-state values
    state_t             w_state_nxt;
    logic [REGSIZE-1:0] w_addr_nxt;
    logic [REGSIZE-1:0] w_remaining_nxt;
    logic [BITSIZE-1:0] w_out_data_nxt;
    logic               w_out_valid_nxt;
    logic               w_out_last_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic [BITSIZE-1:0] w_checksum_nxt;

    // Decoded helpers
    logic [REGSIZE:0]   w_range_end;
    logic               w_range_bad;
    logic               w_accept;
    logic               w_busy;

    assign w_range_end = {1'b0, bus.base_addr} + {1'b0, bus.word_count};
    assign w_range_bad = (w_range_end > C_MEM_LIMIT);
    assign w_accept    = r_out_valid && bus.out_ready;
    assign w_busy      = (r_state == S_FETCH) || (r_state == S_SEND);

    // Next-state and datapath decode for the dump sequencer.
    // NOTE: every signal gets its default first so no path through the case
    // leaves one unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_checksum_nxt  = r_checksum;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // abort beats start in the same cycle; otherwise a start is
                // either an empty dump, a rejected range or a real walk.
                if (!bus.abort && bus.start) begin
                    if (bus.word_count == '0) begin
                        w_checksum_nxt = '0;
                        w_state_nxt    = S_DONE;
                    end else if (w_range_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_addr_nxt      = bus.base_addr;
                        w_remaining_nxt = bus.word_count;
                        w_checksum_nxt  = '0;
                        w_state_nxt     = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                if (bus.abort) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    // The only point where read data is captured.
                    w_out_data_nxt  = bus.mem_rdata;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = (r_remaining == C_ONE);
                    w_state_nxt     = S_SEND;
                end
            end

            S_SEND: begin
                if (bus.abort) begin
                    // Partial checksum is kept; the word on the bus is dropped.
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    w_state_nxt     = S_IDLE;
                end else if (w_accept) begin
                    w_checksum_nxt  = r_checksum + r_out_data;
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    w_remaining_nxt = r_remaining - C_ONE;
                    if (r_remaining == C_ONE) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_addr_nxt  = r_addr + C_ONE;
                        w_state_nxt = S_FETCH;
                    end
                end
            end

            S_DONE: begin
                // An abort here suppresses the completion pulse.
                if (!bus.abort) begin
                    w_done_nxt = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_checksum  <= w_checksum_nxt;
        end
    end

    // The address bus is driven only while the reader owns the memory.
    assign bus.busy      = w_busy;
    assign bus.mem_addr  = w_busy ? r_addr : '0;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.checksum  = r_checksum;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: a behavioural 100-word memory drives
// mem_rdata combinationally; every step advances one clock and checks the
// outputs 1 ns after the rising edge against hand-computed values.
module tb_mem_dump_reader;

    localparam int BITSIZE   = 32;
    localparam int REGSIZE   = 16;
    localparam int MEM_DEPTH = 100;

    logic clk;
    logic reset;

    int errors = 0;
    int checks = 0;

    logic [BITSIZE-1:0] mem [0:MEM_DEPTH-1];

    mem_dump_reader_if #(.BITSIZE(BITSIZE), .REGSIZE(REGSIZE)) bus ();

    mem_dump_reader #(
        .BITSIZE  (BITSIZE),
        .REGSIZE  (REGSIZE),
        .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous memory read port.
    always_comb begin
        if (int'(bus.mem_addr) < MEM_DEPTH) bus.mem_rdata = mem[bus.mem_addr];
        else                                bus.mem_rdata = '0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start command for exactly one edge.
    task automatic start_cmd(input logic [15:0] base, input logic [15:0] count);
        bus.base_addr  = base;
        bus.word_count = count;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'h0;
        mem[10] = 32'h11; mem[11] = 32'h22; mem[12] = 32'h33; mem[13] = 32'h44;
        mem[97] = 32'h100; mem[98] = 32'h200; mem[99] = 32'h300;
        mem[0]  = 32'hFFFF_FFFF; mem[1] = 32'h2;

        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.out_ready  = 1'b1;

        // ---- Reset state ----
        tick(); tick();
        check("rst_busy",     bus.busy,      0);
        check("rst_valid",    bus.out_valid, 0);
        check("rst_last",     bus.out_last,  0);
        check("rst_addr",     bus.mem_addr,  0);
        check("rst_data",     bus.out_data,  0);
        check("rst_cks",      bus.checksum,  0);
        check("rst_done_err", {bus.done, bus.err}, 0);
        reset = 1'b1;
        tick();

        // ---- Test 1: 4 words, sink always ready ----
        start_cmd(16'd10, 16'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_fetch_busy%0d", i), bus.busy, 1);
            check($sformatf("t1_fetch_addr%0d", i), bus.mem_addr, 10 + i);
            tick();
            check($sformatf("t1_data%0d", i),  bus.out_data,  32'h11 * (i + 1));
            check($sformatf("t1_valid%0d", i), bus.out_valid, 1);
            check($sformatf("t1_last%0d", i),  bus.out_last,  (i == 3) ? 1 : 0);
            tick();
            check($sformatf("t1_drop%0d", i),  bus.out_valid, 0);
        end
        check("t1_no_done_yet", bus.done, 0);
        check("t1_busy_in_done", bus.busy, 0);
        tick();
        check("t1_done",  bus.done,     1);
        check("t1_cks",   bus.checksum, 32'hAA);
        tick();
        check("t1_done_pulse", bus.done, 0);
        check("t1_idle_busy",  bus.busy, 0);

        // ---- Test 2: backpressure on word 2, stray start and read-data change ----
        start_cmd(16'd10, 16'd4);
        tick();                               // word 1 presented
        check("t2_w1", bus.out_data, 32'h11);
        tick();                               // word 1 accepted
        tick();                               // word 2 presented
        bus.out_ready = 1'b0;
        check("t2_w2_first", bus.out_data, 32'h22);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.base_addr  = 16'd0;       // ignored: not IDLE
                bus.word_count = 16'd1;
                bus.start      = 1'b1;
                mem[11]        = 32'hDEAD;    // not re-sampled in SEND
            end
            tick();
            bus.start = 1'b0;
            check($sformatf("t2_hold_data%0d", i),  bus.out_data,  32'h22);
            check($sformatf("t2_hold_valid%0d", i), bus.out_valid, 1);
            check($sformatf("t2_hold_addr%0d", i),  bus.mem_addr,  11);
        end
        mem[11] = 32'h22;
        bus.out_ready = 1'b1;
        tick();                               // word 2 accepted
        check("t2_w2_taken", bus.out_valid, 0);
        tick();
        check("t2_w3", bus.out_data, 32'h33);
        tick(); tick();
        check("t2_w4", bus.out_data, 32'h44);
        check("t2_w4_last", bus.out_last, 1);
        tick(); tick();
        check("t2_done", bus.done, 1);
        check("t2_cks",  bus.checksum, 32'hAA);
        tick();

        // ---- Test 3: range check at the top of memory ----
        start_cmd(16'd98, 16'd3);
        check("t3_err",       bus.err,       1);
        check("t3_err_busy",  bus.busy,      0);
        check("t3_err_valid", bus.out_valid, 0);
        tick();
        check("t3_err_pulse", bus.err,       0);
        check("t3_err_idle",  bus.busy,      0);
        check("t3_err_cks",   bus.checksum,  32'hAA);

        start_cmd(16'd97, 16'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_addr%0d", i), bus.mem_addr, 97 + i);
            tick();
            check($sformatf("t3_data%0d", i), bus.out_data, 32'h100 * (i + 1));
            check($sformatf("t3_last%0d", i), bus.out_last, (i == 2) ? 1 : 0);
            tick();
        end
        check("t3_err_none", bus.err, 0);
        tick();
        check("t3_done", bus.done, 1);
        check("t3_cks",  bus.checksum, 32'h600);
        tick();

        // ---- Test 4: empty dump ----
        start_cmd(16'd5, 16'd0);
        check("t4_valid", bus.out_valid, 0);
        check("t4_busy",  bus.busy,      0);
        check("t4_done_early", bus.done, 0);
        check("t4_cks",   bus.checksum,  0);
        tick();
        check("t4_done",  bus.done,      1);
        check("t4_valid2", bus.out_valid, 0);
        tick();
        check("t4_done_pulse", bus.done, 0);

        // ---- Test 5: checksum wrap, then abort in the second SEND ----
        start_cmd(16'd0, 16'd2);
        tick(); tick(); tick(); tick();       // two words out and accepted
        tick();
        check("t5_done", bus.done, 1);
        check("t5_wrap", bus.checksum, 32'h1);
        tick();

        start_cmd(16'd0, 16'd2);
        tick(); tick(); tick();               // word 2 presented
        check("t5_w2", bus.out_data, 32'h2);
        check("t5_w2_valid", bus.out_valid, 1);
        bus.out_ready = 1'b0;
        bus.abort     = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        check("t5_abort_valid", bus.out_valid, 0);
        check("t5_abort_last",  bus.out_last,  0);
        check("t5_abort_busy",  bus.busy,      0);
        tick();
        check("t5_abort_nodone", bus.done, 0);
        check("t5_abort_cks",    bus.checksum, 32'hFFFF_FFFF);

        // ---- Test 6: reset mid-SEND, then abort+start together in IDLE ----
        bus.out_ready = 1'b0;
        start_cmd(16'd10, 16'd4);
        tick();
        check("t6_send_valid", bus.out_valid, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_busy",  bus.busy,      0);
        check("t6_rst_data",  bus.out_data,  0);
        check("t6_rst_cks",   bus.checksum,  0);
        check("t6_rst_addr",  bus.mem_addr,  0);
        tick();
        check("t6_idle", bus.busy, 0);

        bus.out_ready = 1'b1;
        bus.abort     = 1'b1;
        start_cmd(16'd10, 16'd4);
        bus.abort     = 1'b0;
        check("t6_abort_wins", bus.busy, 0);
        tick();
        check("t6_abort_wins2", bus.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
